requant_serializer: RTL and testbench

//  Upstream feeder of the 4-PE output packer. Captures one vector of N_LANE signed

---
 rtl/requant_serializer.sv | 160 ++++++++++++++++
 tb/tb_requant_serializer.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/requant_serializer.sv
// requant_serializer: captures one vector of N_LANE signed accumulators and
// emits them one lane per cycle. Each lane is multiplied by an unsigned scale,
// rounded half up, arithmetically shifted right and saturated to int8. The
// int8 result is sign-extended onto an OUT_W-bit bus.
//
// Optional build macro: NPU_REQUANT_RELU_EN
//   defined   -> ReLU on the saturated result, so the output range is [0,127]
//   undefined -> signed output range [-128,127]
// The port list is the same in both builds.
//
// Handshake: a vector is captured on the rising edge where acc_valid_i and
// acc_ready_o are both high. acc_valid_i without acc_ready_o is ignored, so the
// source must hold the vector until it is taken. The output side has no
// backpressure: out_valid_o is a one-cycle qualifier for each lane result.
module requant_serializer #(
  parameter int N_LANE  = 4,
  parameter int ACC_W   = 24,
  parameter int OUT_W   = 24,
  parameter int SCALE_W = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clear_i,
  input  logic                      acc_valid_i,
  output logic                      acc_ready_o,
  input  logic [N_LANE*ACC_W-1:0]   acc_data_i,
  input  logic [SCALE_W-1:0]        cfg_scale_i,
  input  logic [4:0]                cfg_shift_i,
  output logic                      out_valid_o,
  output logic [OUT_W-1:0]          out_data_o,
  output logic                      out_last_o,
  output logic                      dbg_state_o
);

  localparam int LW = (N_LANE > 1) ? $clog2(N_LANE) : 1;
  localparam int PW = ACC_W + SCALE_W + 1;  // exact signed product width
  localparam int RW = PW + 1;               // headroom for the rounding add
  localparam logic [LW-1:0]        LAST   = LW'(N_LANE - 1);
  localparam logic signed [RW-1:0] SAT_HI = RW'(127);
  localparam logic signed [RW-1:0] SAT_LO = RW'(-128);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_e;

  state_e                    state_q, state_d;
  logic [LW-1:0]             lane_q, lane_d;
  logic signed [ACC_W-1:0]   buf_q [N_LANE];
  logic [SCALE_W-1:0]        scale_q;
  logic [4:0]                shift_q;
  logic                      out_valid_q, out_valid_d;
  logic                      out_last_q, out_last_d;
  logic [OUT_W-1:0]          out_data_q, out_data_d;

  logic                      capture;
  logic                      lane_last;
  logic signed [ACC_W-1:0]   sel;
  logic signed [PW-1:0]      prod;
  logic signed [RW-1:0]      rnd_add;
  logic signed [RW-1:0]      rnd;
  logic signed [RW-1:0]      shifted;
  logic [7:0]                res8;
  logic [OUT_W-1:0]          req_word;

  assign lane_last   = (lane_q == LAST);
  assign acc_ready_o = (state_q == S_IDLE) | ((state_q == S_BUSY) & lane_last);
  assign capture     = acc_valid_i & acc_ready_o;

  // Requantise the lane currently selected from the captured buffer.
  always_comb begin
    sel     = buf_q[lane_q];
    prod    = $signed({{(PW-ACC_W){sel[ACC_W-1]}}, sel})
            * $signed({{(PW-SCALE_W){1'b0}}, scale_q});
    rnd_add = (shift_q == 5'd0) ? '0 : (RW'(1) << (shift_q - 5'd1));
    rnd     = $signed({prod[PW-1], prod}) + rnd_add;
    shifted = rnd >>> shift_q;
    if (shifted > SAT_HI) begin
      res8 = 8'h7F;
    end else if (shifted < SAT_LO) begin
      res8 = 8'h80;
    end else begin
      res8 = shifted[7:0];
    end
`ifdef NPU_REQUANT_RELU_EN
    if (res8[7]) begin
      res8 = 8'h00;
    end
`endif
    req_word = {{(OUT_W-8){res8[7]}}, res8};
  end

  // Next-state and output logic: IDLE waits for a capture, BUSY emits one lane
  // per edge and can take the next vector on its last lane for full throughput.
  always_comb begin
    state_d     = state_q;
    lane_d      = lane_q;
    out_valid_d = 1'b0;
    out_last_d  = 1'b0;
    out_data_d  = out_data_q;
    case (state_q)
      S_IDLE: begin
        if (capture) begin
          state_d = S_BUSY;
          lane_d  = '0;
        end
      end
      S_BUSY: begin
        out_valid_d = 1'b1;
        out_last_d  = lane_last;
        out_data_d  = req_word;
        if (lane_last) begin
          lane_d  = '0;
          state_d = capture ? S_BUSY : S_IDLE;
        end else begin
          lane_d = lane_q + LW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        lane_d  = '0;
      end
    endcase
  end

  // State, output and capture registers; clear_i flushes exactly like reset.
  always_ff @(posedge clk) begin
    if (!rst_n || clear_i) begin
      state_q     <= S_IDLE;
      lane_q      <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
      scale_q     <= '0;
      shift_q     <= '0;
      for (int i = 0; i < N_LANE; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      lane_q      <= lane_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
      if (capture) begin
        scale_q <= cfg_scale_i;
        shift_q <= cfg_shift_i;
        for (int i = 0; i < N_LANE; i++) begin
          buf_q[i] <= acc_data_i[i*ACC_W +: ACC_W];
        end
      end
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign out_data_o  = out_data_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_requant_serializer.sv
// Bench for requant_serializer (N_LANE=4, ACC_W=24, OUT_W=24, SCALE_W=8).
// Expected lane words {last, data} are queued when a vector is captured and
// checked in order whenever out_valid_o is high.
module tb_requant_serializer;

  localparam int NL = 4;
  localparam int AW = 24;
  localparam int OW = 24;

  logic              clk;
  logic              rst_n;
  logic              clear_i;
  logic              acc_valid_i;
  logic              acc_ready_o;
  logic [NL*AW-1:0]  acc_data_i;
  logic [7:0]        cfg_scale_i;
  logic [4:0]        cfg_shift_i;
  logic              out_valid_o;
  logic [OW-1:0]     out_data_o;
  logic              out_last_o;
  logic              dbg_state_o;

  requant_serializer #(
    .N_LANE (NL),
    .ACC_W  (AW),
    .OUT_W  (OW),
    .SCALE_W(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (clear_i),
    .acc_valid_i(acc_valid_i),
    .acc_ready_o(acc_ready_o),
    .acc_data_i (acc_data_i),
    .cfg_scale_i(cfg_scale_i),
    .cfg_shift_i(cfg_shift_i),
    .out_valid_o(out_valid_o),
    .out_data_o (out_data_o),
    .out_last_o (out_last_o),
    .dbg_state_o(dbg_state_o)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int          total = 0;
  int          bad   = 0;
  int          last_cnt = 0;
  logic [24:0] exp_q[$];

  typedef struct {
    logic [7:0] scale;
    logic [4:0] shift;
    int         acc [4];
    int         exp [4];
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, req, $time);
    end
  endtask

  // ReLU build clips negative expectations to zero.
  function automatic int relu(input int x);
`ifdef NPU_REQUANT_RELU_EN
    return (x < 0) ? 0 : x;
`else
    return x;
`endif
  endfunction

  // Reference requant of one lane, in plain 64-bit integer arithmetic.
  function automatic int model(input int a, input int scale, input int shift);
    longint p;
    p = longint'(a) * longint'(scale);
    if (shift > 0) p = (p + (longint'(1) << (shift - 1))) >>> shift;
    if (p > 127) p = 127;
    if (p < -128) p = -128;
    return relu(int'(p));
  endfunction

  task automatic push_exp(input logic [31:0] e8);
    for (int j = 0; j < NL; j++) begin
      exp_q.push_back({(j == NL - 1), {16{e8[j*8+7]}}, e8[j*8 +: 8]});
    end
  endtask

  // Compare every emitted lane against the head of the queue.
  always @(negedge clk) begin
    if (out_valid_o) begin
      if (out_last_o) last_cnt++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got %h with nothing expected at %0t", out_data_o, $time);
      end else begin
        check("lane_out", {7'd0, out_last_o, out_data_o}, {7'd0, exp_q.pop_front()});
      end
    end else if (out_last_o) begin
      check("last_without_valid", {31'd0, out_last_o}, 32'd0);
    end
  end

  // ---------------- driver tasks ----------------
  // Called at posedge+1; returns at posedge+1 just after the capture edge.
  task automatic send_vec(input logic [7:0] sc, input logic [4:0] sh,
                          input logic [NL*AW-1:0] data, input logic [31:0] e8);
    int n;
    n = 0;
    acc_valid_i = 1'b1;
    acc_data_i  = data;
    cfg_scale_i = sc;
    cfg_shift_i = sh;
    while (!acc_ready_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!acc_ready_o) begin
      check("capture_timeout", 32'd0, 32'd1);
      acc_valid_i = 1'b0;
    end else begin
      @(posedge clk);
      push_exp(e8);
      #1;
      // The captured vector must not see these.
      acc_valid_i = 1'b0;
      acc_data_i  = {$urandom, $urandom, $urandom};
      cfg_scale_i = 8'($urandom);
      cfg_shift_i = 5'($urandom);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(name, exp_q.size(), 32'd0);
    exp_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  function automatic logic [NL*AW-1:0] pack_acc(input int a0, input int a1, input int a2, input int a3);
    logic [NL*AW-1:0] d;
    d[0*AW +: AW] = AW'(a0);
    d[1*AW +: AW] = AW'(a1);
    d[2*AW +: AW] = AW'(a2);
    d[3*AW +: AW] = AW'(a3);
    return d;
  endfunction

  function automatic logic [31:0] pack_exp(input int e0, input int e1, input int e2, input int e3);
    logic [31:0] e;
    e[7:0]   = 8'(relu(e0));
    e[15:8]  = 8'(relu(e1));
    e[23:16] = 8'(relu(e2));
    e[31:24] = 8'(relu(e3));
    return e;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    int               a [4];
    logic [7:0]       sc;
    logic [4:0]       sh;
    int               last_base;

    tbl[0] = '{8'd1,   5'd0,  '{10, -5, 127, -128},          '{10, -5, 127, -128}};
    tbl[1] = '{8'd4,   5'd0,  '{100, -100, 31, -32},         '{127, -128, 124, -128}};
    tbl[2] = '{8'd1,   5'd2,  '{6, -6, 5, -7},               '{2, -1, 1, -2}};
    tbl[3] = '{8'd1,   5'd0,  '{-50, 0, 1, -1},              '{-50, 0, 1, -1}};
    tbl[4] = '{8'd255, 5'd8,  '{100, -100, 256, -129},       '{100, -100, 127, -128}};
    tbl[5] = '{8'd255, 5'd31, '{8388607, -8388608, 0, 4210752}, '{1, -1, 0, 0}};
    tbl[6] = '{8'd0,   5'd3,  '{5, -5, 1000, -1000},         '{0, 0, 0, 0}};

    rst_n       = 1'b0;
    clear_i     = 1'b0;
    acc_valid_i = 1'b0;
    acc_data_i  = '0;
    cfg_scale_i = '0;
    cfg_shift_i = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("rst_out_last",  {31'd0, out_last_o},  32'd0);
    check("rst_out_data",  {8'd0, out_data_o},   32'd0);
    check("rst_acc_ready", {31'd0, acc_ready_o}, 32'd1);
    check("rst_state",     {31'd0, dbg_state_o}, 32'd0);
    @(posedge clk); #1;

    // Table vectors, one at a time
    for (int i = 0; i < 7; i++) begin
      send_vec(tbl[i].scale, tbl[i].shift,
               pack_acc(tbl[i].acc[0], tbl[i].acc[1], tbl[i].acc[2], tbl[i].acc[3]),
               pack_exp(tbl[i].exp[0], tbl[i].exp[1], tbl[i].exp[2], tbl[i].exp[3]));
      wait_drain("table_drain");
    end

    // Random vectors sent back to back
    for (int r = 0; r < 6; r++) begin
      sc = 8'($urandom_range(0, 255));
      sh = 5'($urandom_range(0, 12));
      for (int j = 0; j < NL; j++) a[j] = int'($urandom_range(0, 4000)) - 2000;
      send_vec(sc, sh, pack_acc(a[0], a[1], a[2], a[3]),
               pack_exp(model(a[0], int'(sc), int'(sh)), model(a[1], int'(sc), int'(sh)),
                        model(a[2], int'(sc), int'(sh)), model(a[3], int'(sc), int'(sh))));
    end
    wait_drain("random_drain");

    // acc_valid held across two vectors: eight valid cycles with no bubble
    last_base   = last_cnt;
    acc_valid_i = 1'b1;
    acc_data_i  = pack_acc(1, 2, 3, 4);
    cfg_scale_i = 8'd1;
    cfg_shift_i = 5'd0;
    @(posedge clk);
    push_exp(pack_exp(1, 2, 3, 4));
    #1 acc_data_i = pack_acc(-1, -2, -3, -4);
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk);
      if (k == 4) begin
        push_exp(pack_exp(-1, -2, -3, -4));
        #1 acc_valid_i = 1'b0;
      end
      @(negedge clk);
      check("b2b_valid", {31'd0, out_valid_o}, 32'd1);
      if (k == 1 || k == 2) check("b2b_ready_mid", {31'd0, acc_ready_o}, 32'd0);
      if (k == 3) check("b2b_ready_lane3", {31'd0, acc_ready_o}, 32'd1);
      if (k == 1) check("b2b_state_busy", {31'd0, dbg_state_o}, 32'd1);
    end
    @(negedge clk);
    check("b2b_idle_after", {31'd0, out_valid_o}, 32'd0);
    check("b2b_last_pulses", last_cnt - last_base, 32'd2);
    wait_drain("b2b_drain");

    // clear after two lanes: flush, then a fresh vector starts at lane 0
    acc_valid_i = 1'b1;
    acc_data_i  = pack_acc(7, 8, 9, 10);
    cfg_scale_i = 8'd1;
    cfg_shift_i = 5'd0;
    @(posedge clk);
    push_exp(pack_exp(7, 8, 9, 10));
    #1 acc_valid_i = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 clear_i = 1'b1;
    @(posedge clk);
    #1 clear_i = 1'b0;
    check("clear_two_lanes_seen", exp_q.size(), 32'd2);
    exp_q.delete();
    @(negedge clk);
    check("clear_out_valid", {31'd0, out_valid_o}, 32'd0);
    check("clear_acc_ready", {31'd0, acc_ready_o}, 32'd1);
    check("clear_out_data",  {8'd0, out_data_o},   32'd0);
    check("clear_state",     {31'd0, dbg_state_o}, 32'd0);
    repeat (4) begin
      @(negedge clk);
      check("clear_no_more_lanes", {31'd0, out_valid_o}, 32'd0);
    end
    @(posedge clk); #1;
    send_vec(8'd2, 5'd1, pack_acc(11, -11, 64, -65), pack_exp(11, -11, 64, -65));
    wait_drain("after_clear_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
